// File: rtl/acc_rr_sched.sv
// Round-robin scheduler sharing one conditional accumulator among NREQ requesters.
// A granted operand equal to acc doubles acc (mod 2^W); every grant bumps cnt.
module acc_rr_sched #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned W      = 2,
  parameter int unsigned INIT   = 1,
  parameter int unsigned THRESH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] opnd,
  output logic [NREQ-1:0]   gnt,
  output logic              hit,
  output logic [W-1:0]      acc,
  output logic              over,
  output logic              busy,
  output logic [W-1:0]      cnt
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, EXEC} state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   idx;
  logic [W-1:0]    op;

  logic [NREQ-1:0] eligible;
  logic            found;
  logic [IW-1:0]   pick;
  logic [W-1:0]    sel;
  int unsigned     cand;

  // First eligible requester at or after ptr, wrapping; the one being granted is masked.
  always_comb begin
    eligible = req & ~gnt;
    found    = 1'b0;
    pick     = '0;
    sel      = '0;
    cand     = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = 32'(ptr) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!found && eligible[IW'(cand)]) begin
        found = 1'b1;
        pick  = IW'(cand);
      end
    end
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (pick == IW'(k)) sel = opnd[k*W +: W];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      acc   <= W'(INIT);
      cnt   <= '0;
      ptr   <= '0;
      idx   <= '0;
      op    <= '0;
      gnt   <= '0;
      hit   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      gnt <= '0;
      hit <= 1'b0;
      case (state)
        IDLE: begin
          if (en && found) begin
            idx   <= pick;
            op    <= sel;
            busy  <= 1'b1;
            state <= EXEC;
          end
        end
        EXEC: begin
          // Latched operand is used even if the requester has since dropped req.
          gnt <= NREQ'(1) << idx;
          if (op == acc) begin
            acc <= acc + op;
            hit <= 1'b1;
          end
          cnt   <= cnt + 1'b1;
          ptr   <= (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign over = 32'(acc) > THRESH;

endmodule

// File: tb/tb_acc_rr_sched.sv
// Self-checking bench for acc_rr_sched: directed vector table, corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_acc_rr_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [3:0] req;
  logic [7:0] opnd;
  logic [3:0] gnt;
  logic       hit;
  logic [1:0] acc;
  logic       over;
  logic       busy;
  logic [1:0] cnt;

  logic       rst3, en3;
  logic [3:0] req3;
  logic [7:0] opnd3;
  logic [3:0] gnt3;
  logic       hit3, over3, busy3;
  logic [1:0] acc3, cnt3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  acc_rr_sched dut (
    .clk(clk), .reset(reset), .en(en), .req(req), .opnd(opnd),
    .gnt(gnt), .hit(hit), .acc(acc), .over(over), .busy(busy), .cnt(cnt)
  );

  acc_rr_sched #(.INIT(3)) dut3 (
    .clk(clk), .reset(rst3), .en(en3), .req(req3), .opnd(opnd3),
    .gnt(gnt3), .hit(hit3), .acc(acc3), .over(over3), .busy(busy3), .cnt(cnt3)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int         rep;
    logic       rst;
    logic       en;
    logic [3:0] req;
    logic [7:0] opnd;
    logic [3:0] gnt;
    logic       hit;
    logic [1:0] acc;
    logic [1:0] cnt;
    logic       busy;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int rep, input logic rs, input logic e, input logic [3:0] r,
                     input logic [7:0] o, input logic [3:0] g, input logic h,
                     input logic [1:0] a, input logic [1:0] c, input logic b);
    vec_t v;
    v.rep = rep; v.rst = rs; v.en = e; v.req = r; v.opnd = o;
    v.gnt = g; v.hit = h; v.acc = a; v.cnt = c; v.busy = b;
    tbl.push_back(v);
  endtask

  // Reference model: transaction view of one pending selection and the shared accumulator.
  int m_acc, m_cnt, m_ptr, m_idx, m_op, m_gnt, m_hit;
  bit m_exec;

  task automatic model_reset();
    m_acc = 1; m_cnt = 0; m_ptr = 0; m_idx = 0; m_op = 0;
    m_gnt = 0; m_hit = 0; m_exec = 0;
  endtask

  task automatic model_step(input int r, input bit e, input int o);
    int  elig;
    bit  got;
    if (m_exec) begin
      m_gnt  = 1 << m_idx;
      m_hit  = (m_op == m_acc) ? 1 : 0;
      if (m_hit == 1) m_acc = (m_acc + m_op) % 4;
      m_cnt  = (m_cnt + 1) % 4;
      m_ptr  = (m_idx + 1) % 4;
      m_exec = 0;
    end else begin
      elig  = r & ~m_gnt & 15;
      m_gnt = 0;
      m_hit = 0;
      got   = 0;
      if (e && elig != 0) begin
        for (int i = 0; i < 4; i++) begin
          int k;
          k = (m_ptr + i) % 4;
          if (!got && ((elig >> k) & 1) == 1) begin
            got    = 1;
            m_idx  = k;
            m_op   = (o >> (2 * k)) & 3;
            m_exec = 1;
          end
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; req = '0; opnd = '0;
    rst3 = 1'b1; en3 = 1'b1; req3 = '0; opnd3 = '0;

    // INIT=3 variant: over asserted straight out of reset, then cleared by a hit.
    repeat (2) @(posedge clk);
    #1 rst3 = 1'b0;
    check("init3 acc after reset", acc3, 3);
    check("init3 over after reset", over3, 1);
    req3 = 4'b0010; opnd3 = 8'h0C;
    @(posedge clk); #1;
    check("init3 busy", busy3, 1);
    @(posedge clk); #1;
    req3 = '0;
    check("init3 gnt", gnt3, 4'b0010);
    check("init3 hit", hit3, 1);
    check("init3 acc", acc3, 2);
    check("init3 over", over3, 0);

    add(1,  1, 1, 4'b0000, 8'h00, 4'b0000, 0, 1, 0, 0);
    add(5,  0, 1, 4'b0000, 8'h00, 4'b0000, 0, 1, 0, 0);
    add(1,  0, 1, 4'b0001, 8'h01, 4'b0000, 0, 1, 0, 1);
    add(1,  0, 1, 4'b0001, 8'h01, 4'b0001, 1, 2, 1, 0);
    add(1,  0, 1, 4'b0001, 8'h01, 4'b0000, 0, 2, 1, 0);
    add(1,  0, 1, 4'b0001, 8'h01, 4'b0000, 0, 2, 1, 1);
    add(1,  0, 1, 4'b0001, 8'h01, 4'b0001, 0, 2, 2, 0);
    add(1,  0, 1, 4'b0100, 8'h20, 4'b0000, 0, 2, 2, 1);
    add(1,  0, 1, 4'b0100, 8'h20, 4'b0100, 1, 0, 3, 0);
    add(1,  0, 1, 4'b0001, 8'h00, 4'b0000, 0, 0, 3, 1);
    add(1,  0, 1, 4'b0001, 8'h00, 4'b0001, 1, 0, 0, 0);
    add(1,  1, 1, 4'b0000, 8'h00, 4'b0000, 0, 1, 0, 0);
    add(1,  0, 1, 4'b1111, 8'h00, 4'b0000, 0, 1, 0, 1);
    add(1,  0, 1, 4'b1111, 8'h00, 4'b0001, 0, 1, 1, 0);
    add(1,  0, 1, 4'b1111, 8'h00, 4'b0000, 0, 1, 1, 1);
    add(1,  0, 1, 4'b1111, 8'h00, 4'b0010, 0, 1, 2, 0);
    add(1,  0, 1, 4'b1111, 8'h00, 4'b0000, 0, 1, 2, 1);
    add(1,  0, 1, 4'b1111, 8'h00, 4'b0100, 0, 1, 3, 0);
    add(1,  0, 1, 4'b1111, 8'h00, 4'b0000, 0, 1, 3, 1);
    add(1,  0, 1, 4'b1111, 8'h00, 4'b1000, 0, 1, 0, 0);
    add(1,  0, 1, 4'b1111, 8'h00, 4'b0000, 0, 1, 0, 1);
    add(1,  0, 1, 4'b1111, 8'h00, 4'b0001, 0, 1, 1, 0);
    add(10, 0, 0, 4'b0010, 8'h00, 4'b0000, 0, 1, 1, 0);
    add(1,  0, 1, 4'b0010, 8'h00, 4'b0000, 0, 1, 1, 1);
    add(1,  0, 1, 4'b0010, 8'h00, 4'b0010, 0, 1, 2, 0);

    foreach (tbl[i]) begin
      for (int r = 0; r < tbl[i].rep; r++) begin
        reset = tbl[i].rst; en = tbl[i].en; req = tbl[i].req; opnd = tbl[i].opnd;
        @(posedge clk); #1;
        check($sformatf("row%0d gnt", i),  gnt,  tbl[i].gnt);
        check($sformatf("row%0d hit", i),  hit,  tbl[i].hit);
        check($sformatf("row%0d acc", i),  acc,  tbl[i].acc);
        check($sformatf("row%0d cnt", i),  cnt,  tbl[i].cnt);
        check($sformatf("row%0d busy", i), busy, tbl[i].busy);
        check($sformatf("row%0d over", i), over, 0);
      end
    end

    // Reset asserted mid-EXEC abandons the pending grant.
    @(posedge clk); #1;
    check("abort idle", busy, 0);
    @(posedge clk); #1;
    check("abort busy before reset", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("abort busy async", busy, 0);
    check("abort acc async", acc, 1);
    check("abort cnt async", cnt, 0);
    req = '0;
    @(posedge clk); #1;
    check("abort gnt", gnt, 0);
    reset = 1'b0;
    begin
      int seen;
      seen = 0;
      repeat (4) begin
        @(posedge clk); #1;
        if (gnt != 0) seen++;
      end
      check("abort no later gnt", seen, 0);
    end
    check("abort acc", acc, 1);
    check("abort cnt", cnt, 0);

    // Randomized traffic against the reference model.
    reset = 1'b1; req = '0; opnd = '0; en = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      en = ($urandom_range(0, 7) != 0);
      for (int k = 0; k < 4; k++) begin
        if (req[k]) begin
          if (gnt[k]) begin
            if ($urandom_range(0, 1) == 1) req[k] = 1'b0;
          end else if ($urandom_range(0, 15) == 0) begin
            req[k] = 1'b0;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          req[k] = 1'b1;
          opnd[k*2 +: 2] = 2'($urandom_range(0, 3));
        end
      end
      model_step(int'(req), en, int'(opnd));
      @(posedge clk); #1;
      check("rnd gnt", gnt, m_gnt);
      check("rnd hit", hit, m_hit);
      check("rnd acc", acc, m_acc);
      check("rnd cnt", cnt, m_cnt);
      check("rnd busy", busy, int'(m_exec));
      check("rnd over", over, (m_acc > 2) ? 1 : 0);
      check("rnd gnt onehot", int'($countones(gnt) <= 1), 1);
      check("rnd busy and gnt", int'(busy && gnt != 0), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
